// File: rtl/matrix_op_executor.sv
// Matrix operation executor: add/sub/scalar-mul/transpose/matmul on row-major operand RAMs, dims 1..5.
// Optional macro MATRIX_EXEC_SAT_EN saturates every result to 16 bits; without it results wrap.
module matrix_op_executor (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               calc_en,
  input  logic [2:0]         op_type,
  input  logic [2:0]         rows_a,
  input  logic [2:0]         cols_a,
  input  logic [2:0]         rows_b,
  input  logic [2:0]         cols_b,
  input  logic signed [15:0] scalar,
  output logic [4:0]         a_addr,
  output logic [4:0]         b_addr,
  input  logic signed [15:0] a_rdata,
  input  logic signed [15:0] b_rdata,
  output logic [4:0]         res_addr,
  output logic signed [15:0] res_wdata,
  output logic               res_we,
  output logic [2:0]         res_rows,
  output logic [2:0]         res_cols,
  output logic               busy,
  output logic               op_done,
  output logic               op_err
);

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_SMUL   = 3'd2;
  localparam logic [2:0] OP_TRANS  = 3'd3;
  localparam logic [2:0] OP_MATMUL = 3'd4;

  typedef enum logic [2:0] {IDLE, CHECK, RUN, DONE, WAIT_REL} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d, ra_q, ra_d, ca_q, ca_d, rb_q, rb_d, cb_q, cb_d;
  logic signed [15:0] scalar_q, scalar_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2:0]         r_q, r_d, c_q, c_d, ph_q, ph_d;
  logic               rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [4:0]         tgt_q, tgt_d;
  logic signed [37:0] acc_q, acc_d;
  logic               res_we_q, res_we_d;
  logic [4:0]         res_addr_q, res_addr_d;
  logic signed [15:0] res_wdata_q, res_wdata_d;
  logic               err_q, err_d;
  logic [2:0]         res_rows_q, res_rows_d, res_cols_q, res_cols_d;

  logic               is_mm, req_ok, issue_ew, issue_mm;
  logic [5:0]         n_elem;
  logic [4:0]         lin_a_mm, lin_b_mm, lin_tr;
  logic signed [15:0] mul_b;
  logic signed [31:0] prod;
  logic signed [37:0] a_x, b_x, prod_x, result;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'd5);
  endfunction

  function automatic logic signed [15:0] fit16(input logic signed [37:0] v);
`ifdef MATRIX_EXEC_SAT_EN
    if (v > 38'sd32767) return 16'sh7fff;
    else if (v < -38'sd32768) return 16'sh8000;
    else return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  assign is_mm    = (op_q == OP_MATMUL);
  assign n_elem   = 6'(ra_q) * 6'(is_mm ? cb_q : ca_q);
  assign issue_ew = (state_q == RUN) && !is_mm && (cnt_q < n_elem);
  assign issue_mm = (state_q == RUN) && is_mm && (ph_q < ca_q);
  assign lin_a_mm = 5'(r_q) * 5'(ca_q) + 5'(ph_q);
  assign lin_b_mm = 5'(ph_q) * 5'(cb_q) + 5'(c_q);
  assign lin_tr   = 5'(c_q) * 5'(ra_q) + 5'(r_q);

  assign a_x    = {{22{a_rdata[15]}}, a_rdata};
  assign b_x    = {{22{b_rdata[15]}}, b_rdata};
  assign mul_b  = is_mm ? b_rdata : scalar_q;
  assign prod   = a_rdata * mul_b;
  assign prod_x = {{6{prod[31]}}, prod};

  always_comb begin
    req_ok = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB:  req_ok = dim_ok(ra_q) && dim_ok(ca_q) && (ra_q == rb_q) && (ca_q == cb_q);
      OP_SMUL, OP_TRANS: req_ok = dim_ok(ra_q) && dim_ok(ca_q);
      OP_MATMUL:       req_ok = dim_ok(ra_q) && dim_ok(ca_q) && dim_ok(cb_q) && (ca_q == rb_q);
      default:         req_ok = 1'b0;
    endcase
  end

  always_comb begin
    result = a_x;
    case (op_q)
      OP_ADD:    result = a_x + b_x;
      OP_SUB:    result = a_x - b_x;
      OP_SMUL:   result = prod_x;
      OP_MATMUL: result = acc_q + prod_x;
      default:   result = a_x;
    endcase
  end

  always_comb begin
    a_addr = 5'd0;
    b_addr = 5'd0;
    if (issue_ew) begin
      a_addr = cnt_q[4:0];
      if ((op_q == OP_ADD) || (op_q == OP_SUB)) b_addr = cnt_q[4:0];
    end else if (issue_mm) begin
      a_addr = lin_a_mm;
      b_addr = lin_b_mm;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ra_d        = ra_q;
    ca_d        = ca_q;
    rb_d        = rb_q;
    cb_d        = cb_q;
    scalar_d    = scalar_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    c_d         = c_q;
    ph_d        = ph_q;
    acc_d       = acc_q;
    err_d       = err_q;
    res_rows_d  = res_rows_q;
    res_cols_d  = res_cols_q;
    rd_vld_d    = 1'b0;
    rd_last_d   = 1'b0;
    tgt_d       = 5'd0;
    res_we_d    = 1'b0;
    res_addr_d  = 5'd0;
    res_wdata_d = 16'sd0;

    case (state_q)
      IDLE: begin
        if (calc_en) begin
          op_d     = op_type;
          ra_d     = rows_a;
          ca_d     = cols_a;
          rb_d     = rows_b;
          cb_d     = cols_b;
          scalar_d = scalar;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        cnt_d      = 6'd0;
        r_d        = 3'd0;
        c_d        = 3'd0;
        ph_d       = 3'd0;
        acc_d      = 38'sd0;
        err_d      = !req_ok;
        res_rows_d = req_ok ? ((op_q == OP_TRANS) ? ca_q : ra_q) : 3'd0;
        res_cols_d = req_ok ? ((op_q == OP_TRANS) ? ra_q : (is_mm ? cb_q : ca_q)) : 3'd0;
        state_d    = req_ok ? RUN : DONE;
      end
      RUN: begin
        // Data returning from last cycle's read becomes a registered write (or accumulates).
        if (rd_vld_q) begin
          if (!is_mm || rd_last_q) begin
            res_we_d    = 1'b1;
            res_addr_d  = tgt_q;
            res_wdata_d = fit16(result);
          end
          if (is_mm) acc_d = rd_last_q ? 38'sd0 : result;
        end
        if (!is_mm) begin
          if (issue_ew) begin
            rd_vld_d = 1'b1;
            tgt_d    = (op_q == OP_TRANS) ? lin_tr : cnt_q[4:0];
            if (c_q == ca_q - 3'd1) begin
              c_d = 3'd0;
              r_d = r_q + 3'd1;
            end else begin
              c_d = c_q + 3'd1;
            end
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == n_elem + 6'd1) state_d = DONE;
        end else begin
          if (issue_mm) begin
            rd_vld_d  = 1'b1;
            rd_last_d = (ph_q == ca_q - 3'd1);
            tgt_d     = cnt_q[4:0];
          end
          // Each output element owns K+2 cycles: K reads, one accumulate, one write.
          if (ph_q == ca_q + 3'd1) begin
            ph_d  = 3'd0;
            cnt_d = cnt_q + 6'd1;
            if (c_q == cb_q - 3'd1) begin
              c_d = 3'd0;
              r_d = r_q + 3'd1;
            end else begin
              c_d = c_q + 3'd1;
            end
            if (cnt_q == n_elem - 6'd1) state_d = DONE;
          end else begin
            ph_d = ph_q + 3'd1;
          end
        end
      end
      DONE:     state_d = WAIT_REL;
      WAIT_REL: if (!calc_en) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      ra_q        <= 3'd0;
      ca_q        <= 3'd0;
      rb_q        <= 3'd0;
      cb_q        <= 3'd0;
      scalar_q    <= 16'sd0;
      cnt_q       <= 6'd0;
      r_q         <= 3'd0;
      c_q         <= 3'd0;
      ph_q        <= 3'd0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      tgt_q       <= 5'd0;
      acc_q       <= 38'sd0;
      res_we_q    <= 1'b0;
      res_addr_q  <= 5'd0;
      res_wdata_q <= 16'sd0;
      err_q       <= 1'b0;
      res_rows_q  <= 3'd0;
      res_cols_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      ca_q        <= ca_d;
      rb_q        <= rb_d;
      cb_q        <= cb_d;
      scalar_q    <= scalar_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      c_q         <= c_d;
      ph_q        <= ph_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      tgt_q       <= tgt_d;
      acc_q       <= acc_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_wdata_q <= res_wdata_d;
      err_q       <= err_d;
      res_rows_q  <= res_rows_d;
      res_cols_q  <= res_cols_d;
    end
  end

  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;
  assign res_wdata = res_wdata_q;
  assign res_rows  = res_rows_q;
  assign res_cols  = res_cols_q;
  assign op_err    = err_q;
  assign op_done   = (state_q == DONE);
  assign busy      = (state_q == CHECK) || (state_q == RUN) || (state_q == DONE);

endmodule

// File: doc/matrix_op_executor.md
MATRIX_OP_EXECUTOR -- requirements
Module: matrix_op_executor

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- calc_en  in  1  compute request, level, from the top-level controller
- op_type  in  3  000 add, 001 sub, 010 scalar-mul, 011 transpose, 100 matmul, others invalid
- rows_a, cols_a, rows_b, cols_b  in  3 each  operand dimensions; legal range 1..5
- scalar  in  16  signed scalar operand for scalar-mul
- a_addr, b_addr  out  5  operand RAM read addresses, row-major (row*cols+col)
- a_rdata, b_rdata  in  16  signed operand data, valid 1 cycle after address
- res_addr  out  5  result RAM write address, row-major
- res_wdata  out  16  signed result data
- res_we  out  1  result write strobe
- res_rows, res_cols  out  3  result dimensions, valid from op_done onward
- busy  out  1  high from CHECK through DONE
- op_done  out  1  one-cycle completion pulse to the controller
- op_err  out  1  qualifies op_done; high when the request was rejected

Function
REQ-002 The FSM SHALL have states IDLE, CHECK, RUN, DONE and WAIT_REL.
REQ-003 In IDLE with calc_en=1 (cycle 0), the block SHALL latch op_type, all dimensions and scalar, and enter CHECK at cycle 1. Later changes to these inputs SHALL be ignored until IDLE is re-entered.
REQ-004 CHECK SHALL reject the request in these cases:
- invalid op_type;
- any dimension used by the op equal to 0 or greater than 5;
- add/sub with (rows_a,cols_a)≠(rows_b,cols_b);
- matmul with cols_a≠rows_b.
On rejection, the block SHALL go to DONE with op_err=1 and no res_we pulses. Otherwise it SHALL enter RUN at cycle 2.
REQ-005 Elementwise ops (add, sub, scalar-mul, transpose) on R×C SHALL issue one read address per cycle at cycles 2..N+1, with N=R*C, in row-major order.
REQ-006 For each element read at cycle k, the result SHALL be registered and presented with res_we=1 at cycle k+2. Writes therefore occupy cycles 4..N+3, and op_done SHALL pulse at cycle N+4.
REQ-007 Transpose SHALL write element (r,c) to res_addr c*R+r and report res_rows=C, res_cols=R. Other elementwise ops SHALL report R×C.
REQ-008 Matmul (R=rows_a, K=cols_a, C=cols_b) SHALL compute one result element per K+2 cycles, non-overlapped, as follows:
- issue K address pairs;
- accumulate products in a signed accumulator of at least 37 bits, cleared at each element start;
- write the element on the (K+2)th cycle.
op_done SHALL pulse at cycle 2+R*C*(K+2).
REQ-009 Arithmetic SHALL be 16-bit signed. Overflow handling SHALL follow REQ-017.
REQ-010 DONE SHALL last exactly one cycle (op_done=1) and then enter WAIT_REL. WAIT_REL SHALL return to IDLE on the first cycle calc_en=0, so a held calc_en never restarts an operation.
REQ-011 Deassertion of calc_en during CHECK or RUN SHALL be ignored; the operation SHALL always run to completion.
REQ-012 res_we SHALL never be asserted outside RUN and its 2-cycle drain. a_addr, b_addr and res_addr SHALL be 0 when idle.
REQ-013 op_err SHALL hold its value from DONE until the next CHECK. res_rows and res_cols SHALL hold their values until the next CHECK.

Reset
REQ-014 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all outputs, the accumulator and all counters to 0 on that edge.
REQ-015 A reset asserted mid-RUN SHALL abort the operation with no further res_we or op_done. After reset release, the block SHALL accept a new calc_en at the next cycle.

Configuration
REQ-016 The feature SHALL be controlled by macro MATRIX_EXEC_SAT_EN.
REQ-017 With MATRIX_EXEC_SAT_EN defined, every result SHALL saturate to [-32768, 32767]. Without it, results SHALL be the low 16 bits (two's-complement wrap).

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- add 2×2, A=[1,2,3,4], B=[10,20,30,40] -> writes 11,22,33,44 at addr 0..3 on cycles 4..7; op_done at cycle 8; op_err=0.
- transpose 2×3, A=[1..6] -> memory [1,4,2,5,3,6]; res_rows=3, res_cols=2; op_done at cycle 10.
- matmul 2×3 · 3×2, A=[1..6], B=[7..12] -> [58,64,139,154]; op_done at cycle 2+4*5=22.
- add 2×2 with B dims 3×2 -> op_done at cycle 2 with op_err=1, no res_we; calc_en held high -> no restart until calc_en=0 for one cycle.
- scalar-mul, A=[20000], scalar=2 -> 32767 with MATRIX_EXEC_SAT_EN, -25536 without.
- rst_n=0 at cycle 5 of a 5×5 add -> all outputs 0 next cycle, no op_done; a new request completes normally.
